// File: rtl/block_cmd_queue.sv
// Command decoder and FIFO for block commands written by software into r29 (blockID_data).
// Optional push counter output cmd_total is built when BLOCKQ_STATS_EN is defined.
module block_cmd_queue #(
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned NUM_BLOCKS = 100,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clock,
  input  logic                     ctrl_resetn,
  input  logic [31:0]              blockID_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_op,
  output logic [IDX_W-1:0]         out_index,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     overflow,
  output logic [7:0]               illegal_cnt
`ifdef BLOCKQ_STATS_EN
  ,
  output logic [15:0]              cmd_total
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_BAD   = 2'b11;

  logic [31:0]      prevWord;
  logic [1:0]       opMem  [DEPTH];
  logic [IDX_W-1:0] idxMem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [PW:0]      count;

  logic             newCmd;
  logic             legal;
  logic             full;
  logic             pop;
  logic             push;
  logic [1:0]       cmdOp;
  logic [IDX_W-1:0] cmdIdx;

  always_comb begin
    cmdOp  = blockID_data[29:28];
    cmdIdx = blockID_data[IDX_W-1:0];
    newCmd = (blockID_data != prevWord) && blockID_data[30];
    legal  = newCmd && (cmdOp != OP_BAD) &&
             ((cmdOp == OP_CLEAR) || (32'(cmdIdx) < NUM_BLOCKS));
    full   = (count == (PW+1)'(DEPTH));
    pop    = out_valid && out_ready;
    push   = legal && (!full || pop);
  end

  // Head fields are gated to zero when empty so reset/empty reads as all-zero.
  always_comb begin
    out_valid = (count != '0);
    out_op    = out_valid ? opMem[rdPtr]  : '0;
    out_index = out_valid ? idxMem[rdPtr] : '0;
    out_count = count;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      opMem[wrPtr]  <= cmdOp;
      idxMem[wrPtr] <= (cmdOp == OP_CLEAR) ? '0 : cmdIdx;
    end
  end

  always_ff @(posedge clock or negedge ctrl_resetn) begin
    if (!ctrl_resetn) begin
      prevWord    <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      prevWord <= blockID_data;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (legal && full && !pop) overflow <= 1'b1;
      if (newCmd && !legal && (illegal_cnt != 8'hFF)) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

`ifdef BLOCKQ_STATS_EN
  always_ff @(posedge clock or negedge ctrl_resetn) begin
    if (!ctrl_resetn) cmd_total <= '0;
    else if (push)    cmd_total <= cmd_total + 1'b1;
  end
`endif

endmodule
